// File: rtl/btn_pkg.sv
// Shared button-handling types: debounce FSM state encoding.
package btn_pkg;

   typedef enum logic [1:0] {
      S_LOW  = 2'd0,
      S_RISE = 2'd1,
      S_HIGH = 2'd2,
      S_FALL = 2'd3
   } btn_state_t;

endpackage

// File: rtl/button_filter_tick_gen.sv
// Sample-tick prescaler: one-cycle tick every TICK_DIV clk_in cycles.
module tick_gen #(
   parameter int unsigned TICK_DIV = 100000
) (
   input  logic clk_in,
   input  logic rst,
   output logic tick
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] tick_cnt;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (tick_cnt == LAST) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + CW'(1);
      end
   end

   assign tick = (tick_cnt == LAST);

endmodule

// File: rtl/button_filter.sv
// Counter-based debounce filter with long-press detection for one raw button pin.
module button_filter
   import btn_pkg::*;
#(
   parameter int unsigned TICK_DIV   = 100000,
   parameter int unsigned STABLE_CNT = 10,
   parameter int unsigned HOLD_CNT   = 1000
) (
   input  logic clk_in,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_hold
);

   localparam int unsigned SW = $clog2(STABLE_CNT);
   localparam int unsigned HW = $clog2(HOLD_CNT + 1);
   localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CNT - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CNT);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CNT - 1);

   logic          tick;
   logic          sync0;
   logic          sync1;
   btn_state_t    state;
   btn_state_t    state_nxt;
   logic [SW-1:0] stab_cnt;
   logic [SW-1:0] stab_nxt;
   logic [HW-1:0] hold_cnt;
   logic [HW-1:0] hold_nxt;
   logic          level_nxt;
   logic          hold_pulse_nxt;

   tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick_gen (
      .clk_in(clk_in),
      .rst   (rst),
      .tick  (tick)
   );

   always_ff @(posedge clk_in) begin
      if (rst) begin
         sync0     <= 1'b0;
         sync1     <= 1'b0;
         state     <= S_LOW;
         stab_cnt  <= '0;
         hold_cnt  <= '0;
         btn_level <= 1'b0;
         btn_hold  <= 1'b0;
      end else begin
         sync0     <= btn_in;
         sync1     <= sync0;
         state     <= state_nxt;
         stab_cnt  <= stab_nxt;
         hold_cnt  <= hold_nxt;
         btn_level <= level_nxt;
         btn_hold  <= hold_pulse_nxt;
      end
   end

   // State moves only on sample ticks; the level output trails the state by one cycle.
   always_comb begin
      state_nxt      = state;
      stab_nxt       = stab_cnt;
      hold_nxt       = hold_cnt;
      hold_pulse_nxt = 1'b0;
      level_nxt      = btn_level;

      if (state == S_HIGH) begin
         level_nxt = 1'b1;
      end else if (state == S_LOW) begin
         level_nxt = 1'b0;
      end

      if (tick) begin
         case (state)
            S_LOW: begin
               if (sync1) begin
                  state_nxt = S_RISE;
                  stab_nxt  = SW'(1);
               end
            end
            S_RISE: begin
               if (!sync1) begin
                  state_nxt = S_LOW;
               end else if (stab_cnt == STAB_LAST) begin
                  state_nxt = S_HIGH;
                  hold_nxt  = '0;
               end else begin
                  stab_nxt = stab_cnt + SW'(1);
               end
            end
            S_HIGH: begin
               if (!sync1) begin
                  state_nxt = S_FALL;
                  stab_nxt  = SW'(1);
               end else if (hold_cnt < HOLD_MAX) begin
                  hold_nxt       = hold_cnt + HW'(1);
                  hold_pulse_nxt = (hold_cnt == HOLD_LAST);
               end
            end
            S_FALL: begin
               if (sync1) begin
                  state_nxt = S_HIGH;
               end else if (stab_cnt == STAB_LAST) begin
                  state_nxt = S_LOW;
                  hold_nxt  = '0;
               end else begin
                  stab_nxt = stab_cnt + SW'(1);
               end
            end
            default: state_nxt = S_LOW;
         endcase
      end
   end

endmodule

// File: tb/tb_button_filter.sv
// Directed bench for button_filter with TICK_DIV=4, STABLE_CNT=3, HOLD_CNT=5.
module tb_button_filter;

   logic clk_in = 1'b0;
   logic rst    = 1'b1;
   logic btn_in = 1'b1;
   logic btn_level;
   logic btn_hold;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int hold_pulses = 0;
   int hold_cyc    = -1;

   typedef struct {
      logic rst;
      logic btn;
      int   cycles;
      int   lvl;   // -1 = not checked
      int   hold;  // -1 = not checked
   } seg_t;

   localparam int NSEG = 17;
   seg_t segs [NSEG];

   button_filter #(
      .TICK_DIV  (4),
      .STABLE_CNT(3),
      .HOLD_CNT  (5)
   ) dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .btn_in   (btn_in),
      .btn_level(btn_level),
      .btn_hold (btn_hold)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   always @(negedge clk_in) begin
      if (btn_hold === 1'b1) begin
         hold_pulses <= hold_pulses + 1;
         hold_cyc    <= cyc;
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_range(input string nm, input int act, input int lo, input int hi);
      n_tests++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   task automatic step(input logic r, input logic b);
      rst    = r;
      btn_in = b;
      @(posedge clk_in);
      #1;
   endtask

   // Drive constant inputs until btn_level reaches lvl; rel = cycle index or -1 on timeout.
   task automatic run_until(input logic b, input logic lvl, input int max_cyc, output int rel);
      rel = -1;
      for (int c = 0; c < max_cyc; c++) begin
         step(1'b0, b);
         if (btn_level === lvl) begin
            rel = c;
            break;
         end
      end
   endtask

   task automatic long_press(input int idx);
      int p0;
      int rise_rel;
      int rise_cyc;
      p0       = hold_pulses;
      rise_rel = -1;
      rise_cyc = 0;
      for (int c = 0; c < 60; c++) begin
         step(1'b0, 1'b1);
         if (rise_rel < 0 && btn_level === 1'b1) begin
            rise_rel = c;
            rise_cyc = cyc;
         end
      end
      check_range($sformatf("press%0d_rise", idx), rise_rel, 10, 15);
      check($sformatf("press%0d_hold_count", idx), hold_pulses - p0, 1);
      check_range($sformatf("press%0d_hold_delay", idx), hold_cyc - rise_cyc, 17, 24);
      for (int c = 0; c < 30; c++) step(1'b0, 1'b0);
      check($sformatf("press%0d_released", idx), int'(btn_level), 0);
      check($sformatf("press%0d_no_extra_hold", idx), hold_pulses - p0, 1);
   endtask

   initial begin
      int rel;
      int p0;

      segs[0]  = '{1'b1, 1'b1,  3,  0,  0};
      segs[1]  = '{1'b0, 1'b1, 10,  0,  0};
      segs[2]  = '{1'b0, 1'b1,  6, -1,  0};
      segs[3]  = '{1'b0, 1'b1, 10,  1,  0};
      segs[4]  = '{1'b0, 1'b0, 10,  1,  0};
      segs[5]  = '{1'b0, 1'b0,  6, -1,  0};
      segs[6]  = '{1'b0, 1'b0, 20,  0,  0};
      segs[7]  = '{1'b0, 1'b1,  6,  0,  0};
      segs[8]  = '{1'b0, 1'b0, 40,  0,  0};
      segs[9]  = '{1'b0, 1'b1, 16, -1,  0};
      segs[10] = '{1'b0, 1'b0,  6,  1, -1};
      segs[11] = '{1'b0, 1'b1,  6,  1, -1};
      segs[12] = '{1'b0, 1'b0,  6,  1, -1};
      segs[13] = '{1'b0, 1'b1, 10,  1, -1};
      segs[14] = '{1'b0, 1'b0, 10,  1, -1};
      segs[15] = '{1'b0, 1'b0,  6, -1, -1};
      segs[16] = '{1'b0, 1'b0, 20,  0,  0};

      for (int s = 0; s < NSEG; s++) begin
         for (int c = 0; c < segs[s].cycles; c++) begin
            step(segs[s].rst, segs[s].btn);
            if (segs[s].lvl >= 0)
               check($sformatf("seg%0d_c%0d_level", s, c), int'(btn_level), segs[s].lvl);
            if (segs[s].hold >= 0)
               check($sformatf("seg%0d_c%0d_hold", s, c), int'(btn_hold), segs[s].hold);
         end
      end

      long_press(1);
      long_press(2);

      // Bring the level up, then reset for one cycle mid-press.
      run_until(1'b1, 1'b1, 20, rel);
      check_range("pre_reset_rise", rel, 10, 15);
      p0 = hold_pulses;
      step(1'b1, 1'b1);
      check("midreset_level", int'(btn_level), 0);
      check("midreset_hold", int'(btn_hold), 0);
      run_until(1'b1, 1'b1, 20, rel);
      check_range("post_reset_rise", rel, 10, 15);
      check("post_reset_no_hold", hold_pulses - p0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
